// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus between a program source and instr_encoder.
`default_nettype none

interface instr_encoder_if #(
  parameter int AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [7:0]    req_arg;
  logic          im_we;
  logic [AW-1:0] im_addr;
  logic [8:0]    im_wdata;

  modport master (
    output req_valid, req_op, req_arg,
    input  req_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  req_valid, req_op, req_arg,
    output req_ready, im_we, im_addr, im_wdata
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// Packs opcode/operand requests into 9-bit instruction words and writes them
// sequentially into instruction memory; LI expands into a PUT+LI pair.
`default_nettype none

module instr_encoder #(
  parameter int AW         = 10,
  parameter int START_ADDR = 0
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        start,
  instr_encoder_if.slave   bus,
  output logic [AW:0]      word_count,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_full
);

  localparam logic [AW:0] c_START = (AW+1)'(START_ADDR);
  localparam logic [AW:0] c_LAST  = (AW+1)'((1 << AW) - 1);
  localparam logic [3:0]  c_OP_LI  = 4'b0000;
  localparam logic [3:0]  c_OP_ILL = 4'b1110;
  localparam logic [3:0]  c_OP_PUT = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT2 = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW:0]   r_ptr, w_ptr_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_we, w_we_nxt;
  logic [8:0]    r_wdata, w_wdata_nxt;
  logic          r_err_ill, w_err_ill_nxt;
  logic          r_err_full, w_err_full_nxt;
  logic          w_ready;
  logic          w_accept;
  logic          w_write;
  logic [8:0]    w_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= c_START;
      r_addr     <= c_START[AW-1:0];
      r_count    <= '0;
      r_we       <= 1'b0;
      r_wdata    <= '0;
      r_err_ill  <= 1'b0;
      r_err_full <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_addr     <= w_addr_nxt;
      r_count    <= w_count_nxt;
      r_we       <= w_we_nxt;
      r_wdata    <= w_wdata_nxt;
      r_err_ill  <= w_err_ill_nxt;
      r_err_full <= w_err_full_nxt;
    end
  end

  always_comb begin
    w_ready        = (r_state == S_IDLE) && !start && rst_n;
    w_accept       = bus.req_valid && w_ready;
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_addr_nxt     = r_addr;
    w_count_nxt    = r_count;
    w_we_nxt       = 1'b0;
    w_wdata_nxt    = r_wdata;
    w_err_ill_nxt  = r_err_ill;
    w_err_full_nxt = r_err_full;
    w_write        = 1'b0;
    w_word         = '0;

    if (start) begin
      w_state_nxt    = S_IDLE;
      w_ptr_nxt      = c_START;
      w_addr_nxt     = c_START[AW-1:0];
      w_count_nxt    = '0;
      w_err_ill_nxt  = 1'b0;
      w_err_full_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (bus.req_op == c_OP_ILL) begin
              w_err_ill_nxt = 1'b1;
            end else if (bus.req_op == c_OP_LI && r_ptr == c_LAST) begin
              // Only one slot left: LI cannot be split, so it is swallowed.
              w_err_full_nxt = 1'b1;
              w_state_nxt    = S_FULL;
            end else begin
              w_write = 1'b1;
              if (bus.req_op == c_OP_LI || bus.req_op == c_OP_PUT) begin
                w_word = {bus.req_arg, 1'b1};
              end else begin
                w_word = {bus.req_arg[3:0], bus.req_op, 1'b0};
              end
              if (bus.req_op == c_OP_LI) begin
                w_state_nxt = S_EMIT2;
              end
            end
          end
        end
        S_EMIT2: begin
          w_write     = 1'b1;
          w_word      = {4'b0000, c_OP_LI, 1'b0};
          w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_FULL;
        end
      endcase

      if (w_write) begin
        w_we_nxt    = 1'b1;
        w_wdata_nxt = w_word;
        w_addr_nxt  = r_ptr[AW-1:0];
        w_ptr_nxt   = r_ptr + 1'b1;
        w_count_nxt = r_count + 1'b1;
        if (r_ptr == c_LAST) begin
          w_state_nxt = S_FULL;
        end
      end
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.im_we     = r_we;
  assign bus.im_addr   = r_addr;
  assign bus.im_wdata  = r_wdata;
  assign word_count    = r_count;
  assign busy          = (r_state == S_EMIT2);
  assign err_illegal   = r_err_ill;
  assign err_full      = r_err_full;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// Drives a 1024-word and a 4-word encoder in lockstep against a word-list reference model.
`default_nettype none

module tb_instr_encoder;

  logic clk;
  logic rst_n;
  logic start;

  instr_encoder_if #(.AW(10)) ifa ();
  instr_encoder_if #(.AW(2))  ifb ();

  logic [10:0] cnt_a;
  logic [2:0]  cnt_b;
  logic        busy_a, busy_b, ill_a, ill_b, full_a, full_b;

  instr_encoder #(.AW(10), .START_ADDR(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifa),
    .word_count(cnt_a), .busy(busy_a), .err_illegal(ill_a), .err_full(full_a)
  );

  instr_encoder #(.AW(2), .START_ADDR(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(ifb),
    .word_count(cnt_b), .busy(busy_b), .err_illegal(ill_b), .err_full(full_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model, one entry per DUT: capacity in words, next free slot,
  // the LI tail word still owed, and the last presented write.
  int         m_cap  [2] = '{1024, 4};
  int         m_ptr  [2] = '{0, 0};
  int         m_cnt  [2] = '{0, 0};
  bit         m_ill  [2] = '{0, 0};
  bit         m_ful  [2] = '{0, 0};
  bit         m_stuck[2] = '{0, 0};
  int         m_owed [2] = '{0, 0};
  bit         m_we   [2] = '{0, 0};
  int         m_addr [2] = '{0, 0};
  logic [8:0] m_data [2] = '{9'h0, 9'h0};

  function automatic bit model_ready(int d, bit st, bit rn);
    return rn && !st && (m_owed[d] == 0) && !m_stuck[d];
  endfunction

  task automatic emit(int d, logic [8:0] w);
    m_we[d]   = 1'b1;
    m_data[d] = w;
    m_addr[d] = m_ptr[d];
    m_ptr[d]++;
    m_cnt[d]++;
    if (m_ptr[d] == m_cap[d]) m_stuck[d] = 1'b1;
  endtask

  task automatic model_edge(int d, bit v, logic [3:0] op, logic [7:0] a, bit st, bit rn);
    bit rdy;
    int need;
    rdy = model_ready(d, st, rn);
    m_we[d] = 1'b0;
    if (!rn || st) begin
      m_ptr[d] = 0; m_cnt[d] = 0; m_ill[d] = 0; m_ful[d] = 0;
      m_stuck[d] = 0; m_owed[d] = 0; m_addr[d] = 0;
      if (!rn) m_data[d] = 9'h0;
    end else if (m_owed[d] != 0) begin
      emit(d, 9'h000);
      m_owed[d] = 0;
    end else if (v && rdy) begin
      if (op == 4'hE) begin
        m_ill[d] = 1'b1;
      end else begin
        need = (op == 4'h0) ? 2 : 1;
        if (need > m_cap[d] - m_ptr[d]) begin
          m_ful[d]   = 1'b1;
          m_stuck[d] = 1'b1;
        end else begin
          if (op == 4'h0 || op == 4'hF) emit(d, {a, 1'b1});
          else                          emit(d, {a[3:0], op, 1'b0});
          if (op == 4'h0) m_owed[d] = 1;
        end
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(int d, string p, logic we, logic [31:0] addr, logic [8:0] data,
                           logic [31:0] cnt, logic bsy, logic ill, logic ful, logic rdy);
    chk({p, "_we"},    32'(we),   32'(m_we[d]));
    chk({p, "_addr"},  addr,      32'(m_addr[d]));
    chk({p, "_wdata"}, 32'(data), 32'(m_data[d]));
    chk({p, "_count"}, cnt,       32'(m_cnt[d]));
    chk({p, "_busy"},  32'(bsy),  32'(m_owed[d] != 0));
    chk({p, "_ill"},   32'(ill),  32'(m_ill[d]));
    chk({p, "_full"},  32'(ful),  32'(m_ful[d]));
    chk({p, "_ready"}, 32'(rdy),  32'(model_ready(d, start, rst_n)));
  endtask

  task automatic step(bit v, logic [3:0] op, logic [7:0] a, bit st, bit rn);
    ifa.req_valid = v; ifa.req_op = op; ifa.req_arg = a;
    ifb.req_valid = v; ifb.req_op = op; ifb.req_arg = a;
    start = st;
    rst_n = rn;
    @(posedge clk);
    model_edge(0, v, op, a, st, rn);
    model_edge(1, v, op, a, st, rn);
    @(negedge clk);
    check_dut(0, "A", ifa.im_we, 32'(ifa.im_addr), ifa.im_wdata, 32'(cnt_a),
              busy_a, ill_a, full_a, ifa.req_ready);
    check_dut(1, "B", ifb.im_we, 32'(ifb.im_addr), ifb.im_wdata, 32'(cnt_b),
              busy_b, ill_b, full_b, ifb.req_ready);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    bit         v, st, rn;
    logic [3:0] op;
    logic [7:0] a;

    rst_n = 1'b0; start = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_op = 4'h0; ifa.req_arg = 8'h00;
    ifb.req_valid = 1'b0; ifb.req_op = 4'h0; ifb.req_arg = 8'h00;
    @(negedge clk);

    do_reset();
    chk("rst_ready", 32'(ifa.req_ready), 32'd0);
    chk("rst_wdata", 32'(ifa.im_wdata), 32'd0);

    step(1'b1, 4'b0011, 8'h05, 1'b0, 1'b1);
    chk("t1_wdata", 32'(ifa.im_wdata), 32'(9'b0101_0011_0));
    chk("t1_count", 32'(cnt_a), 32'd1);

    do_reset();
    step(1'b1, 4'b0000, 8'hA7, 1'b0, 1'b1);
    chk("t2_put", 32'(ifa.im_wdata), 32'(9'b10100111_1));
    chk("t2_ready_low", 32'(ifa.req_ready), 32'd0);
    idle();
    chk("t2_li", 32'(ifa.im_wdata), 32'd0);
    chk("t2_li_addr", 32'(ifa.im_addr), 32'd1);
    chk("t2_ready_back", 32'(ifa.req_ready), 32'd1);

    do_reset();
    step(1'b1, 4'b0101, 8'h31, 1'b0, 1'b1);
    step(1'b1, 4'b0110, 8'h42, 1'b0, 1'b1);
    step(1'b1, 4'b1000, 8'h53, 1'b0, 1'b1);
    chk("t3_addr", 32'(ifa.im_addr), 32'd2);
    chk("t3_ready", 32'(ifa.req_ready), 32'd1);
    idle();

    step(1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
    step(1'b1, 4'b0001, 8'h01, 1'b0, 1'b1);
    step(1'b1, 4'b0010, 8'h02, 1'b0, 1'b1);
    step(1'b1, 4'b1111, 8'hC3, 1'b0, 1'b1);
    step(1'b1, 4'b0000, 8'h99, 1'b0, 1'b1);
    chk("t4_full", 32'(full_b), 32'd1);
    chk("t4_no_write", 32'(ifb.im_we), 32'd0);
    chk("t4_count", 32'(cnt_b), 32'd3);
    step(1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
    chk("t4_start_addr", 32'(ifb.im_addr), 32'd0);
    chk("t4_start_err", 32'(full_b), 32'd0);

    step(1'b1, 4'b1110, 8'hFF, 1'b0, 1'b1);
    chk("t5_ill", 32'(ill_a), 32'd1);
    step(1'b1, 4'b0100, 8'h07, 1'b0, 1'b1);
    chk("t5_ill_sticky", 32'(ill_a), 32'd1);

    step(1'b1, 4'b0000, 8'h33, 1'b0, 1'b1);
    step(1'b0, 4'h0, 8'h00, 1'b1, 1'b1);
    chk("t6_addr", 32'(ifa.im_addr), 32'd0);
    chk("t6_we", 32'(ifa.im_we), 32'd0);
    idle();
    chk("t6_no_tail", 32'(ifa.im_we), 32'd0);

    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 4'($urandom_range(0, 15));
      a  = 8'($urandom);
      st = ($urandom_range(0, 39) == 0);
      rn = ($urandom_range(0, 99) != 0);
      step(v, op, a, st, rn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
